// File: rtl/cc_life_counter.sv
// rtl/cc_life_counter.sv - frog life counter FSM (GAMEOVER/ALIVE/GRACE), registered outputs.
// Define CC_LIFE_COUNTER_GRACE_EN to build the GRACE invulnerability state and its timer.
module cc_life_counter #(
  parameter int LIFECOUNTER_DATAWIDTH   = 3,
  parameter int LIFECOUNTER_INITLIVES   = 3,
  parameter int LIFECOUNTER_MAXLIVES    = 7,
  parameter int LIFECOUNTER_GRACEWIDTH  = 26,
  parameter int LIFECOUNTER_GRACECYCLES = 50000000
) (
  input  logic                             CC_LIFE_COUNTER_CLOCK_50,
  input  logic                             CC_LIFE_COUNTER_RESET_InLow,
  input  logic                             CC_LIFE_COUNTER_load_InHigh,
  input  logic                             CC_LIFE_COUNTER_hit_InHigh,
  input  logic                             CC_LIFE_COUNTER_bonus_InHigh,
  output logic [LIFECOUNTER_DATAWIDTH-1:0] CC_LIFE_COUNTER_data_OutBUS,
  output logic                             CC_LIFE_COUNTER_gameover_OutHigh,
  output logic                             CC_LIFE_COUNTER_invincible_OutHigh,
  output logic                             CC_LIFE_COUNTER_lost_OutHigh
);

  localparam logic [1:0] ST_GAMEOVER = 2'd0;
  localparam logic [1:0] ST_ALIVE    = 2'd1;
`ifdef CC_LIFE_COUNTER_GRACE_EN
  localparam logic [1:0] ST_GRACE    = 2'd2;
  localparam logic [LIFECOUNTER_GRACEWIDTH-1:0] GRACE_LOAD =
    LIFECOUNTER_GRACEWIDTH'(LIFECOUNTER_GRACECYCLES - 1);
`endif

  localparam logic [LIFECOUNTER_DATAWIDTH-1:0] INIT_C = LIFECOUNTER_DATAWIDTH'(LIFECOUNTER_INITLIVES);
  localparam logic [LIFECOUNTER_DATAWIDTH-1:0] MAX_C  = LIFECOUNTER_DATAWIDTH'(LIFECOUNTER_MAXLIVES);
  localparam logic [LIFECOUNTER_DATAWIDTH-1:0] ONE_C  = LIFECOUNTER_DATAWIDTH'(1);

  logic [1:0]                       state_q, state_d;
  logic [LIFECOUNTER_DATAWIDTH-1:0] count_q, count_d;
  logic                             lost_q, lost_d;
  logic                             gameover_q;
`ifdef CC_LIFE_COUNTER_GRACE_EN
  logic [LIFECOUNTER_GRACEWIDTH-1:0] timer_q, timer_d;
  logic                              invincible_q;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lost_d  = 1'b0;
`ifdef CC_LIFE_COUNTER_GRACE_EN
    timer_d = timer_q;
`endif
    if (CC_LIFE_COUNTER_load_InHigh) begin
      count_d = INIT_C;
      state_d = ST_ALIVE;
`ifdef CC_LIFE_COUNTER_GRACE_EN
      timer_d = '0;
`endif
    end else begin
      case (state_q)
        ST_ALIVE: begin
          // A hit swallows a same-cycle bonus.
          if (CC_LIFE_COUNTER_hit_InHigh) begin
            lost_d = 1'b1;
            if (count_q > ONE_C) begin
              count_d = count_q - ONE_C;
`ifdef CC_LIFE_COUNTER_GRACE_EN
              state_d = ST_GRACE;
              timer_d = GRACE_LOAD;
`endif
            end else begin
              count_d = '0;
              state_d = ST_GAMEOVER;
            end
          end else if (CC_LIFE_COUNTER_bonus_InHigh && (count_q < MAX_C)) begin
            count_d = count_q + ONE_C;
          end
        end
`ifdef CC_LIFE_COUNTER_GRACE_EN
        ST_GRACE: begin
          if (CC_LIFE_COUNTER_bonus_InHigh && (count_q < MAX_C)) begin
            count_d = count_q + ONE_C;
          end
          if (timer_q == '0) begin
            state_d = ST_ALIVE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
`endif
        default: begin
          count_d = '0;
          state_d = ST_GAMEOVER;
        end
      endcase
    end
  end

  always_ff @(posedge CC_LIFE_COUNTER_CLOCK_50) begin
    if (!CC_LIFE_COUNTER_RESET_InLow) begin
      state_q    <= ST_GAMEOVER;
      count_q    <= '0;
      lost_q     <= 1'b0;
      gameover_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lost_q     <= lost_d;
      gameover_q <= (state_d == ST_GAMEOVER);
    end
  end

`ifdef CC_LIFE_COUNTER_GRACE_EN
  always_ff @(posedge CC_LIFE_COUNTER_CLOCK_50) begin
    if (!CC_LIFE_COUNTER_RESET_InLow) begin
      timer_q      <= '0;
      invincible_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      invincible_q <= (state_d == ST_GRACE);
    end
  end

  assign CC_LIFE_COUNTER_invincible_OutHigh = invincible_q;
`else
  assign CC_LIFE_COUNTER_invincible_OutHigh = 1'b0;
`endif

  assign CC_LIFE_COUNTER_data_OutBUS      = count_q;
  assign CC_LIFE_COUNTER_gameover_OutHigh = gameover_q;
  assign CC_LIFE_COUNTER_lost_OutHigh     = lost_q;

endmodule

// File: tb/tb_cc_life_counter.sv
// tb/tb_cc_life_counter.sv - directed plus randomized checks of cc_life_counter against a lives/grace model.
// Follows CC_LIFE_COUNTER_GRACE_EN the same way the design does.
module tb_cc_life_counter;
  localparam int DW    = 3;
  localparam int INIT  = 3;
  localparam int MAXL  = 7;
  localparam int GW    = 3;
  localparam int GRACE = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load = 1'b0;
  logic          hit = 1'b0;
  logic          bonus = 1'b0;
  logic [DW-1:0] data;
  logic          gameover;
  logic          invincible;
  logic          lost;

  int checks = 0;
  int errors = 0;

  int m_lives = 0;
  int m_grace = 0;
  bit m_over  = 1'b1;
  bit m_lost  = 1'b0;

  cc_life_counter #(
    .LIFECOUNTER_DATAWIDTH  (DW),
    .LIFECOUNTER_INITLIVES  (INIT),
    .LIFECOUNTER_MAXLIVES   (MAXL),
    .LIFECOUNTER_GRACEWIDTH (GW),
    .LIFECOUNTER_GRACECYCLES(GRACE)
  ) dut (
    .CC_LIFE_COUNTER_CLOCK_50          (clk),
    .CC_LIFE_COUNTER_RESET_InLow       (rstn),
    .CC_LIFE_COUNTER_load_InHigh       (load),
    .CC_LIFE_COUNTER_hit_InHigh        (hit),
    .CC_LIFE_COUNTER_bonus_InHigh      (bonus),
    .CC_LIFE_COUNTER_data_OutBUS       (data),
    .CC_LIFE_COUNTER_gameover_OutHigh  (gameover),
    .CC_LIFE_COUNTER_invincible_OutHigh(invincible),
    .CC_LIFE_COUNTER_lost_OutHigh      (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // m_grace counts the invulnerable cycles still to come; 0 means not in GRACE.
  task automatic model(input bit r, input bit l, input bit h, input bit b);
    m_lost = 1'b0;
    if (!r) begin
      m_lives = 0; m_over = 1'b1; m_grace = 0;
    end else if (l) begin
      m_lives = INIT; m_over = 1'b0; m_grace = 0;
    end else if (m_over) begin
      m_lives = 0;
    end else if (m_grace > 0) begin
      if (b) m_lives = (m_lives < MAXL) ? m_lives + 1 : MAXL;
      m_grace--;
    end else if (h) begin
      m_lives--;
      m_lost = 1'b1;
      if (m_lives == 0) m_over = 1'b1;
`ifdef CC_LIFE_COUNTER_GRACE_EN
      else m_grace = GRACE;
`endif
    end else if (b) begin
      m_lives = (m_lives < MAXL) ? m_lives + 1 : MAXL;
    end
  endtask

  task automatic step(input bit r, input bit l, input bit h, input bit b);
    rstn = r; load = l; hit = h; bonus = b;
    @(posedge clk);
    model(r, l, h, b);
    #1;
    check("data",       32'(data),       32'(m_lives));
    check("gameover",   32'(gameover),   32'(m_over));
    check("invincible", 32'(invincible), 32'(m_grace > 0));
    check("lost",       32'(lost),       32'(m_lost));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    // Reset, then idle in GAMEOVER with hit/bonus ignored.
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);

    // Single hit and the full grace window.
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    idle(6);

    // Hit held for 12 cycles.
    step(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0);
    check("held_hit_gameover", 32'(gameover), 32'd1);
    check("held_hit_data",     32'(data),     32'd0);

    // Bonus saturation at MAXLIVES.
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
    end
    check("bonus_saturate", 32'(data), 32'(MAXL));

    // Hit+bonus in ALIVE, then load+hit during GRACE.
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    step(1, 1, 1, 0);
    idle(2);

    // Reset in the middle of GRACE.
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(2);

    // Bonus during GRACE.
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    idle(5);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
